// File: rtl/mult_result_serializer_if.sv
// Valid/ready stream bus of parameterized width. The optional last flag is
// driven by the master side only; the slave side ignores it.
interface mult_result_serializer_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mult_result_serializer.sv
// Splits one wide multiplier product into WORD_WIDTH words, least-significant
// word first, with a valid/ready handshake on both sides.
module mult_result_serializer #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  mult_result_serializer_if.slave   prod_i,
  mult_result_serializer_if.master  words_o
);
  localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH + ((DATA_WIDTH % WORD_WIDTH) != 0 ? 1 : 0);
  localparam int HOLD_W    = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_last;
  logic               in_rdy, out_vld, out_last;

  assign is_last = (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (prod_i.valid) begin
          hold_d  = HOLD_W'(prod_i.data);
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_vld  = 1'b1;
        out_last = is_last;
        // A new product may only enter as the last word leaves, giving no bubble.
        in_rdy   = is_last && words_o.ready;
        if (words_o.ready) begin
          if (!is_last) begin
            hold_d = hold_q >> WORD_WIDTH;
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (prod_i.valid) begin
            hold_d = HOLD_W'(prod_i.data);
            cnt_d  = '0;
          end else begin
            hold_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prod_i.ready  = in_rdy;
  assign words_o.valid = out_vld;
  assign words_o.last  = out_last;
  assign words_o.data  = hold_q[WORD_WIDTH-1:0];
endmodule

// File: tb/tb_mult_result_serializer.sv
// Bench for mult_result_serializer: 128/32, 72/32 and 32/32 configurations.
module tb_mult_result_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  mult_result_serializer_if #(.W(128)) in128 ();
  mult_result_serializer_if #(.W(32))  out128 ();
  mult_result_serializer_if #(.W(72))  in72 ();
  mult_result_serializer_if #(.W(32))  out72 ();
  mult_result_serializer_if #(.W(32))  in32 ();
  mult_result_serializer_if #(.W(32))  out32 ();

  assign in128.last = 1'b0;
  assign in72.last  = 1'b0;
  assign in32.last  = 1'b0;

  mult_result_serializer #(.DATA_WIDTH(128), .WORD_WIDTH(32)) u128 (
    .clk_i(clk), .rst_i(rst), .prod_i(in128), .words_o(out128));
  mult_result_serializer #(.DATA_WIDTH(72), .WORD_WIDTH(32)) u72 (
    .clk_i(clk), .rst_i(rst), .prod_i(in72), .words_o(out72));
  mult_result_serializer #(.DATA_WIDTH(32), .WORD_WIDTH(32)) u32 (
    .clk_i(clk), .rst_i(rst), .prod_i(in32), .words_o(out32));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0]      d;
    logic [3:0][31:0]  w;
  } vec_t;
  vec_t tbl [5];

  // Called just after a falling edge with the serializer idle.
  task automatic send128(input string nm, input logic [127:0] d, input logic [3:0][31:0] w);
    in128.valid = 1'b1; in128.data = d; out128.ready = 1'b1; #1;
    chk($sformatf("%s idle ready_o", nm), in128.ready, 1);
    chk($sformatf("%s idle valid_o", nm), out128.valid, 0);
    @(negedge clk);
    in128.valid = 1'b0; in128.data = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("%s w%0d valid", nm, k), out128.valid, 1);
      chk($sformatf("%s w%0d word", nm, k), out128.data, w[k]);
      chk($sformatf("%s w%0d last", nm, k), out128.last, k == 3);
      @(negedge clk);
    end
    #1 chk($sformatf("%s drained", nm), out128.valid, 0);
  endtask

  initial begin
    logic [31:0]  prev_w;
    logic         prev_stall;
    int           idx;
    bit           done;
    logic [31:0]  b2b [8];
    logic [31:0]  w72 [3];
    logic [31:0]  d32 [4];
    logic [127:0] sb [$];
    logic [127:0] acc;
    logic [127:0] exp_p;
    logic [63:0]  a, b;
    int           wi, nprod, nsent;
    bit           in_hs, out_hs;

    tbl[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF,
               {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}};
    tbl[1] = '{{128{1'b1}}, {4{32'hFFFFFFFF}}};
    tbl[2] = '{128'h1, {32'h0, 32'h0, 32'h0, 32'h1}};
    tbl[3] = '{128'h80000000_00000000_00000000_00000000,
               {32'h80000000, 32'h0, 32'h0, 32'h0}};
    tbl[4] = '{128'hDEADBEEF_00000000_CAFEF00D_12345678,
               {32'hDEADBEEF, 32'h0, 32'hCAFEF00D, 32'h12345678}};

    in128.valid = 0; in128.data = '0; out128.ready = 0;
    in72.valid  = 0; in72.data  = '0; out72.ready  = 0;
    in32.valid  = 0; in32.data  = '0; out32.ready  = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset valid_o", out128.valid, 0);
    chk("reset ready_o", in128.ready, 1);
    chk("reset word_o", out128.data, 0);
    chk("reset last_o", out128.last, 0);
    chk("reset72 valid_o", out72.valid, 0);
    chk("reset32 ready_o", in32.ready, 1);
    @(negedge clk);

    // Table vectors with ready_i held high.
    for (int i = 0; i < 5; i++) send128($sformatf("vec%0d", i), tbl[i].d, tbl[i].w);

    // Backpressure on the basic vector.
    in128.valid = 1'b1; in128.data = tbl[0].d; out128.ready = 1'b0;
    @(negedge clk); in128.valid = 1'b0;
    prev_stall = 1'b0; prev_w = '0; idx = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      out128.ready = 1'($urandom_range(0, 1)); #1;
      chk("bp valid", out128.valid, 1);
      if (prev_stall) chk("bp stable", out128.data, prev_w);
      chk("bp ready_o", in128.ready, (idx == 3) && out128.ready);
      if (out128.ready) begin
        chk($sformatf("bp word%0d", idx), out128.data, tbl[0].w[idx]);
        chk($sformatf("bp last%0d", idx), out128.last, idx == 3);
        if (idx == 3) done = 1;
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_w = out128.data;
      end
      @(negedge clk);
    end
    chk("bp complete", done, 1);
    out128.ready = 1'b0; #1;
    chk("bp drained", out128.valid, 0);
    @(negedge clk);

    // Back-to-back products with valid_i held high.
    b2b = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h2, 32'h0, 32'h0, 32'h0};
    in128.valid = 1'b1; in128.data = 128'h1; out128.ready = 1'b1;
    @(negedge clk); in128.data = 128'h2;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("b2b w%0d valid", k), out128.valid, 1);
      chk($sformatf("b2b w%0d word", k), out128.data, b2b[k]);
      chk($sformatf("b2b w%0d last", k), out128.last, (k % 4) == 3);
      chk($sformatf("b2b w%0d ready_o", k), in128.ready, (k % 4) == 3);
      @(negedge clk);
      if (k == 3) in128.valid = 1'b0;
    end
    #1 chk("b2b drained", out128.valid, 0);
    @(negedge clk);

    // Reset after word 1 of a product; reset also beats a pending input.
    in128.valid = 1'b1; in128.data = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C; out128.ready = 1'b1;
    @(negedge clk); in128.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; in128.valid = 1'b1; in128.data = 128'h77;
    @(negedge clk);
    rst = 1'b0; in128.valid = 1'b0; #1;
    chk("rst-mid valid_o", out128.valid, 0);
    chk("rst-mid ready_o", in128.ready, 1);
    chk("rst-mid word_o", out128.data, 0);
    chk("rst-mid last_o", out128.last, 0);
    @(negedge clk);
    send128("post-rst", 128'h5, {32'h0, 32'h0, 32'h0, 32'h5});

    // Padding on the 72-bit instance.
    w72 = '{32'h9ABCDEF0, 32'h12345678, 32'h000000AB};
    in72.valid = 1'b1; in72.data = 72'hAB_12345678_9ABCDEF0; out72.ready = 1'b1;
    @(negedge clk); in72.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pad w%0d valid", k), out72.valid, 1);
      chk($sformatf("pad w%0d word", k), out72.data, w72[k]);
      chk($sformatf("pad w%0d last", k), out72.last, k == 2);
      @(negedge clk);
    end
    #1 chk("pad drained", out72.valid, 0);
    @(negedge clk);

    // Single-word configuration streams one product per cycle.
    d32 = '{32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h0};
    in32.valid = 1'b1; in32.data = d32[0]; out32.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) in32.data = d32[k+1];
      else in32.valid = 1'b0;
      #1;
      chk($sformatf("nw1 w%0d valid", k), out32.valid, 1);
      chk($sformatf("nw1 w%0d word", k), out32.data, d32[k]);
      chk($sformatf("nw1 w%0d last", k), out32.last, 1);
      chk($sformatf("nw1 w%0d ready_o", k), in32.ready, 1);
    end
    @(negedge clk); #1;
    chk("nw1 drained", out32.valid, 0);
    @(negedge clk);

    // Random 64x64 products with random valid/ready, reassembled and scored.
    wi = 0; nprod = 0; nsent = 0; acc = '0;
    in128.valid = 1'b0;
    for (int c = 0; c < 20000 && nprod < 100; c++) begin
      if (!in128.valid) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        in128.data  = {64'b0, a} * {64'b0, b};
        in128.valid = (nsent < 100) && ($urandom_range(0, 1) == 1);
      end
      out128.ready = 1'($urandom_range(0, 1));
      #1;
      in_hs  = in128.valid && in128.ready;
      out_hs = out128.valid && out128.ready;
      if (out_hs) begin
        acc[wi*32 +: 32] = out128.data;
        chk("rand last", out128.last, wi == 3);
        if (wi == 3) begin
          exp_p = (sb.size() > 0) ? sb.pop_front() : 'x;
          chk($sformatf("rand product %0d", nprod), acc, exp_p);
          nprod++;
          wi = 0;
        end else begin
          wi++;
        end
      end
      if (in_hs) begin
        sb.push_back(in128.data);
        nsent++;
      end
      @(negedge clk);
      if (in_hs) in128.valid = 1'b0;
    end
    chk("rand product count", nprod, 100);
    in128.valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult_result_serializer.md
MULT_RESULT_SERIALIZER -- requirements
Module: mult_result_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of the product word accepted from the multiplier stage.
REQ-002 Parameter WORD_WIDTH, default 32: width of each output word.
REQ-003 Derived NUM_WORDS = DATA_WIDTH/WORD_WIDTH + (DATA_WIDTH%WORD_WIDTH != 0); NUM_WORDS >= 1 required.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  product on data_i valid.
REQ-007 data_i  input  DATA_WIDTH  product from multiplier result_o.
REQ-008 ready_o  output  1  block can accept data_i this cycle.
REQ-009 valid_o  output  1  word_o/last_o valid.
REQ-010 word_o  output  WORD_WIDTH  current output word.
REQ-011 last_o  output  1  word_o is the final word of the current product.
REQ-012 ready_i  input  1  downstream accepts word_o this cycle.

Function
REQ-013 Input handshake occurs on a rising edge with valid_i && ready_o; output handshake occurs on a rising edge with valid_o && ready_i.
REQ-014 State machine: IDLE (no product held) and SEND (product held, words pending).
REQ-015 IDLE: ready_o=1, valid_o=0; an input handshake loads data_i, zero-extended to NUM_WORDS*WORD_WIDTH, into a hold/shift register, clears the word counter, and enters SEND.
REQ-016 SEND: valid_o=1; word_o = hold bits [WORD_WIDTH-1:0], so words are emitted least-significant first.
REQ-017 last_o=1 exactly when valid_o=1 and word counter = NUM_WORDS-1; otherwise last_o=0.
REQ-018 An output handshake on a non-last word shifts the hold register right by WORD_WIDTH and increments the counter.
REQ-019 An output handshake on the last word returns to IDLE unless an input handshake occurs in the same cycle.
REQ-020 In SEND, ready_o = last_o && ready_i (combinational from ready_i); otherwise ready_o=0.
REQ-021 Simultaneous last-word output handshake and input handshake: the new product loads and SEND is retained, so word 0 of the new product appears on the next cycle with no bubble.
REQ-022 Latency: word 0 is valid on the cycle after the input handshake. With ready_i held high, a product drains in NUM_WORDS cycles and sustained throughput is one product per NUM_WORDS cycles.
REQ-023 While valid_o=1 and ready_i=0, word_o, last_o and valid_o hold stable; valid_o never deasserts without a handshake.
REQ-024 NUM_WORDS=1: every word has last_o=1; back-to-back products stream at one per cycle.
REQ-025 Upper padding bits of the final word are 0 when DATA_WIDTH is not a multiple of WORD_WIDTH.
REQ-026 data_i is ignored whenever no input handshake occurs; it is not sampled in SEND except under REQ-021.

Reset
REQ-027 With rst_i=1 at a rising edge, the next state is IDLE, counter=0 and hold register=0, giving valid_o=0, last_o=0, word_o=0 and ready_o=1 from the following cycle.
REQ-028 Reset mid-transfer discards all remaining words of the held product; no partial product is emitted after reset.
REQ-029 rst_i has priority over a simultaneous input or output handshake.

Verification
REQ-030 Basic: DATA_WIDTH=128, WORD_WIDTH=32, ready_i=1, data_i=0x00112233_44556677_8899AABB_CCDDEEFF -> word_o = CCDDEEFF, 8899AABB, 44556677, 00112233 on 4 consecutive cycles starting 1 cycle after accept; last_o only on 00112233.
REQ-031 Backpressure: same data, ready_i randomly 0/1 (50%) -> identical word sequence; word_o stable while ready_i=0; ready_o=0 until the last-word handshake.
REQ-032 Back-to-back: valid_i held 1 with products P0=0x1, P1=0x2, ready_i=1 -> 8 consecutive valid words 00000001,0,0,0,00000002,0,0,0; P1 accepted in the same cycle as P0's last word.
REQ-033 Padding: DATA_WIDTH=72, data_i=0xAB_12345678_9ABCDEF0 -> words 9ABCDEF0, 12345678, 000000AB; last_o on the third word.
REQ-034 Reset mid-transfer: assert rst_i for 1 cycle after word 1 of a 4-word product -> valid_o=0 and ready_o=1 on the next cycle; a new product 0x5 then emits 00000005,0,0,0 cleanly.
REQ-035 Chained with the multiplier (A_WIDTH=B_WIDTH=64, random valid/ready, 100 products) -> every reassembled 128-bit value equals a*b, with no errors.
